// File: rtl/sync_fifo_param.sv
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full/almost-empty flags, overflow and
//               underflow pulses, and registered or first-word-fall-through
//               read data.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     EN,
  input  logic                     WR,
  input  logic [DATA_W-1:0]        dataIn,
  input  logic                     RD,
  output logic [DATA_W-1:0]        dataOut,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     ALMOST_EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);

  // Thresholds narrowed to the count width so comparisons are width-matched.
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] AF_CNT   = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_CNT   = AE_LEVEL[AW:0];
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  // Reject configurations the pointer arithmetic cannot support.
  generate
    if (DATA_W < 1) begin : g_bad_width
      $error("sync_fifo_param: DATA_W must be >= 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of 2 and >= 2");
    end
    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
      $error("sync_fifo_param: require AE_LEVEL < AF_LEVEL <= DEPTH");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          rd_ok;
  logic          wr_ok;
  logic          overflow_q;
  logic          underflow_q;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Occupancy and status flags decoded from the registered pointers.
  always_comb begin
    count        = wr_ptr - rd_ptr;
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    ALMOST_EMPTY = (count <= AE_CNT);
    ALMOST_FULL  = (count >= AF_CNT);
  end

  assign COUNT = count;
  assign EMPTY = empty;
  assign FULL  = full;

  // Accept a read only when data exists; a write into a full FIFO is allowed
  // when the same cycle frees a slot with an accepted read.
  always_comb begin
    rd_ok = EN & RD & ~empty;
    wr_ok = EN & WR & (~full | rd_ok);
  end

  // Pointer advance; reset discards every stored entry.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents survive reset and only the pointers are cleared.
  always_ff @(posedge Clk) begin
    if (!Rst && wr_ok) begin
      mem[wr_idx] <= dataIn;
    end
  end

  // Rejected-request pulses, one cycle after the offending attempt.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= EN & WR & ~wr_ok;
      underflow_q <= EN & RD & ~rd_ok;
    end
  end

  assign OVERFLOW  = overflow_q;
  assign UNDERFLOW = underflow_q;

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is presented directly; zero while nothing is stored.
      assign dataOut = empty ? '0 : mem[rd_idx];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      // Registered read: capture the head on an accepted pop, hold otherwise.
      always_ff @(posedge Clk) begin
        if (Rst) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= mem[rd_idx];
        end
      end

      assign dataOut = dout_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param. Drives a registered
//               read instance and a FWFT instance with identical stimulus and
//               checks both against a queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

  localparam int DW    = 32;
  localparam int DEP   = 8;
  localparam int AF    = DEP - 2;
  localparam int AE    = 2;

  logic          Clk;
  logic          Rst;
  logic          EN;
  logic          WR;
  logic          RD;
  logic [DW-1:0] dataIn;

  logic [DW-1:0] dout_s, dout_f;
  logic [3:0]    cnt_s, cnt_f;
  logic          emp_s, full_s, ae_s, af_s, ovf_s, unf_s;
  logic          emp_f, full_f, ae_f, af_f, ovf_f, unf_f;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
    .dataOut(dout_s), .COUNT(cnt_s), .EMPTY(emp_s), .FULL(full_s),
    .ALMOST_EMPTY(ae_s), .ALMOST_FULL(af_s), .OVERFLOW(ovf_s), .UNDERFLOW(unf_s)
  );

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fw (
    .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
    .dataOut(dout_f), .COUNT(cnt_f), .EMPTY(emp_f), .FULL(full_f),
    .ALMOST_EMPTY(ae_f), .ALMOST_FULL(af_f), .OVERFLOW(ovf_f), .UNDERFLOW(unf_f)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned   cnt;
    logic [DW-1:0] dstd;
    logic [DW-1:0] dfw;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dstd;
  int            tests;
  int            failed;
  int            cyc;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Apply one cycle of stimulus and queue the state the FIFO must show after the edge.
  task automatic step(input logic rst, input logic en, input logic wr, input logic rd,
                      input logic [DW-1:0] din);
    exp_t e;
    bit   rd_ok, wr_ok, ovf, unf;
    @(negedge Clk);
    Rst = rst; EN = en; WR = wr; RD = rd; dataIn = din;
    ovf = 1'b0;
    unf = 1'b0;
    if (rst) begin
      mq.delete();
      m_dstd = '0;
    end else if (en) begin
      rd_ok = rd && (mq.size() != 0);
      wr_ok = wr && ((mq.size() < DEP) || rd_ok);
      ovf   = wr && !wr_ok;
      unf   = rd && !rd_ok;
      if (rd_ok) m_dstd = mq.pop_front();
      if (wr_ok) mq.push_back(din);
    end
    e.cnt  = mq.size();
    e.dstd = m_dstd;
    e.dfw  = (mq.size() == 0) ? '0 : mq[0];
    e.ovf  = ovf;
    e.unf  = unf;
    sb.push_back(e);
  endtask

  // Monitor: after every edge, compare both instances with the oldest expectation.
  always begin
    exp_t e;
    @(posedge Clk);
    #2;
    cyc++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("count_std", DW'(cnt_s), DW'(e.cnt));
      chk("count_fwft", DW'(cnt_f), DW'(e.cnt));
      chk("empty", DW'(emp_s), DW'(e.cnt == 0));
      chk("full", DW'(full_s), DW'(e.cnt == DEP));
      chk("almost_empty", DW'(ae_s), DW'(e.cnt <= AE));
      chk("almost_full", DW'(af_s), DW'(e.cnt >= AF));
      chk("fwft_flags", DW'({emp_f, full_f, ae_f, af_f}),
          DW'({e.cnt == 0, e.cnt == DEP, e.cnt <= AE, e.cnt >= AF}));
      chk("overflow", DW'({ovf_s, ovf_f}), DW'({e.ovf, e.ovf}));
      chk("underflow", DW'({unf_s, unf_f}), DW'({e.unf, e.unf}));
      chk("dout_std", dout_s, e.dstd);
      chk("dout_fwft", dout_f, e.dfw);
    end
  end

  initial begin
    int pw, pr;
    tests  = 0;
    failed = 0;
    cyc    = 0;
    m_dstd = '0;
    Rst = 1'b1; EN = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;

    // Reset for two clocks.
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 32'hDEAD);

    // Fill 1..8, then one write too many.
    for (int i = 1; i <= 8; i++) step(0, 1, 1, 0, i);
    step(0, 1, 1, 0, 32'h99);
    // Drain in order, then one read too many.
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);

    // Full FIFO with simultaneous read and write.
    for (int i = 1; i <= 8; i++) step(0, 1, 1, 0, 32'h100 + i);
    step(0, 1, 1, 1, 32'hAA);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0);

    // Stream 20 writes with reads from an occupancy of 3; pointers wrap.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 32'h200 + i);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 1, 32'h300 + i);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);

    // Empty FIFO: write 0x55, idle a cycle, then pop it.
    step(0, 1, 1, 0, 32'h55);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    // Simultaneous read and write into an empty FIFO.
    step(0, 1, 1, 1, 32'h66);
    step(0, 1, 0, 1, 0);

    // Disabled cycles with requests toggling, then reset while disabled at count 5.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 32'h400 + i);
    for (int i = 0; i < 6; i++) step(0, 0, 1'($urandom), 1'($urandom), $urandom);
    step(1, 0, 1, 1, 32'h77);
    step(0, 1, 0, 0, 0);

    // Randomised traffic with shifting read/write bias and occasional resets.
    for (int ph = 0; ph < 8; ph++) begin
      pw = (ph % 2 == 0) ? 80 : 30;
      pr = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 50; i++) begin
        step(($urandom % 80) == 0, ($urandom % 10) != 0,
             ($urandom % 100) < pw, ($urandom % 100) < pr, $urandom);
      end
    end

    // Let the monitor consume the remaining expectations, with a bound.
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge Clk);
    if (sb.size() != 0) begin
      failed++;
      tests++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
